// File: rtl/dsp_buf_pkg.sv
// Shared defaults and state encoding for the frame output buffer.
package dsp_buf_pkg;

    localparam int unsigned DEF_DATA_WIDTH  = 12;
    localparam int unsigned DEF_BUFFER_SIZE = 256;
    localparam int unsigned DEF_ADDR_W      = $clog2(DEF_BUFFER_SIZE);

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } buf_state_e;

endpackage

// File: rtl/frame_buffer_ram.sv
// Frame sample storage: synchronous write, asynchronous read, contents not reset.
module frame_buffer_ram #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/frame_output_buffer.sv
// Buffers one frame written by address and streams it out in order over valid/ready.
// Optional FRAME_OUTBUF_WR_ERR_EN adds a sticky wr_err flag for writes attempted during a drain.
module frame_output_buffer
    import dsp_buf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned BUFFER_SIZE = DEF_BUFFER_SIZE,
    parameter int unsigned ADDR_W      = $clog2(BUFFER_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  frame_done,
    output logic                  buffer_busy,
    output logic [DATA_WIDTH-1:0] sample_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  last_out,
    output logic                  frame_sent
`ifdef FRAME_OUTBUF_WR_ERR_EN
    ,
    output logic                  wr_err
`endif
);

    localparam logic [ADDR_W-1:0] PtrLast = ADDR_W'(BUFFER_SIZE - 1);

    buf_state_e            state_q, state_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] sample_q, sample_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  frame_sent_q, frame_sent_d;

    logic                  xfer;
    logic                  ram_we;
    logic [ADDR_W-1:0]     rd_ptr_nxt;
    logic [ADDR_W-1:0]     ram_raddr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign xfer       = valid_q & ready_in;
    assign rd_ptr_nxt = ADDR_W'(rd_ptr_q + 1'b1);
    assign ram_we     = wr_en & (state_q == FILL);
    // In FILL the read port pre-fetches index 0 for the first beat.
    assign ram_raddr  = (state_q == FILL) ? '0 : rd_ptr_nxt;

    frame_buffer_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUFFER_SIZE),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL: begin
                if (frame_done) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (xfer && (rd_ptr_q == PtrLast)) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        sample_d     = sample_q;
        valid_d      = valid_q;
        last_d       = last_q;
        frame_sent_d = 1'b0;
        unique case (state_q)
            FILL: begin
                if (frame_done) begin
                    rd_ptr_d = '0;
                    valid_d  = 1'b1;
                    last_d   = 1'b0;
                    // Bypass a same-cycle write to index 0 into the first beat.
                    sample_d = (wr_en && (wr_addr == '0)) ? wr_data : ram_rdata;
                end
            end
            DRAIN: begin
                if (xfer) begin
                    if (rd_ptr_q == PtrLast) begin
                        rd_ptr_d     = '0;
                        valid_d      = 1'b0;
                        last_d       = 1'b0;
                        frame_sent_d = 1'b1;
                    end else begin
                        rd_ptr_d = rd_ptr_nxt;
                        sample_d = ram_rdata;
                        last_d   = (rd_ptr_nxt == PtrLast);
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q     <= '0;
            sample_q     <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            frame_sent_q <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            sample_q     <= sample_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
            frame_sent_q <= frame_sent_d;
        end
    end

    assign buffer_busy = (state_q == DRAIN);
    assign sample_out  = sample_q;
    assign valid_out   = valid_q;
    assign last_out    = last_q;
    assign frame_sent  = frame_sent_q;

`ifdef FRAME_OUTBUF_WR_ERR_EN
    logic wr_err_q, wr_err_d;

    always_comb begin
        wr_err_d = wr_err_q | (wr_en & (state_q == DRAIN));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_err_d;
        end
    end

    assign wr_err = wr_err_q;
`endif

endmodule

// File: tb/tb_frame_output_buffer.sv
// Randomized self-checking bench for frame_output_buffer against a frame-level reference model.
module tb_frame_output_buffer;

    localparam int unsigned DW = 12;
    localparam int unsigned N  = 256;
    localparam int unsigned AW = $clog2(N);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          frame_done = 1'b0;
    logic          buffer_busy;
    logic [DW-1:0] sample_out;
    logic          valid_out;
    logic          ready_in = 1'b0;
    logic          last_out;
    logic          frame_sent;
`ifdef FRAME_OUTBUF_WR_ERR_EN
    logic          wr_err;
`endif

    frame_output_buffer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_done  (frame_done),
        .buffer_busy (buffer_busy),
        .sample_out  (sample_out),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .last_out    (last_out),
        .frame_sent  (frame_sent)
`ifdef FRAME_OUTBUF_WR_ERR_EN
        ,
        .wr_err      (wr_err)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: frame contents, drain position and pending completion pulse.
    int unsigned   n_vec = 0;
    int unsigned   n_err = 0;
    logic [DW-1:0] model_mem [N];
    bit            m_drain = 0;
    int unsigned   m_idx = 0;
    bit            m_sent = 0;
    bit            m_err = 0;
    int unsigned   m_beats = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("valid_out", 32'(valid_out), 32'(m_drain));
        check("buffer_busy", 32'(buffer_busy), 32'(m_drain));
        check("frame_sent", 32'(frame_sent), 32'(m_sent));
        if (m_drain) begin
            check("sample_out", 32'(sample_out), 32'(model_mem[m_idx]));
            check("last_out", 32'(last_out), 32'(m_idx == N - 1));
        end else begin
            check("last_out_idle", 32'(last_out), 32'd0);
        end
`ifdef FRAME_OUTBUF_WR_ERR_EN
        check("wr_err", 32'(wr_err), 32'(m_err));
`endif
    endtask

    // One cycle: check what the last edge produced, drive inputs, advance the model.
    task automatic step(input bit we, input int unsigned addr, input int unsigned data,
                        input bit fd, input bit rdy);
        @(negedge clk);
        check_outputs();
        wr_en      = we;
        wr_addr    = AW'(addr);
        wr_data    = DW'(data);
        frame_done = fd;
        ready_in   = rdy;
        m_sent = 0;
        if (m_drain) begin
            if (we) m_err = 1;
            if (rdy) begin
                m_beats++;
                if (m_idx == N - 1) begin
                    m_drain = 0;
                    m_idx   = 0;
                    m_sent  = 1;
                end else begin
                    m_idx++;
                end
            end
        end else begin
            if (we) model_mem[addr] = DW'(data);
            if (fd) begin
                m_drain = 1;
                m_idx   = 0;
                m_beats = 0;
            end
        end
    endtask

    // ready pattern: 0 = always ready, 1 = alternating, 2 = random.
    task automatic drain(input int mode, input bit noise);
        int cyc = 0;
        bit rdy;
        while (m_drain && cyc < 3000) begin
            case (mode)
                0: rdy = 1;
                1: rdy = (cyc % 2) == 0;
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            if (noise)
                step($urandom_range(0, 7) == 0, $urandom_range(0, N - 1), $urandom,
                     $urandom_range(0, 15) == 0, rdy);
            else
                step(0, 0, 0, 0, rdy);
            cyc++;
        end
        check("drain_timeout", 32'(m_drain), 32'd0);
    endtask

    task automatic fill(input bit rnd);
        for (int i = 0; i < N; i++) step(1, i, rnd ? $urandom : i, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        wr_en = 0;
        frame_done = 0;
        ready_in = 0;
        reset_n = 0;
        #1;
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_sample", 32'(sample_out), 32'd0);
        check("rst_last", 32'(last_out), 32'd0);
        check("rst_sent", 32'(frame_sent), 32'd0);
        check("rst_busy", 32'(buffer_busy), 32'd0);
`ifdef FRAME_OUTBUF_WR_ERR_EN
        check("rst_wr_err", 32'(wr_err), 32'd0);
`endif
        m_drain = 0;
        m_idx   = 0;
        m_sent  = 0;
        m_err   = 0;
        @(negedge clk);
        reset_n = 1;
    endtask

    initial begin
        do_reset();

        // Ramp frame, full-rate drain.
        fill(0);
        step(0, 0, 0, 1, 1);
        drain(0, 0);
        step(0, 0, 0, 0, 0);

        // Same frame with alternating ready.
        step(0, 0, 0, 1, 0);
        drain(1, 0);
        step(0, 0, 0, 0, 0);

        // Write during drain must be dropped.
        step(0, 0, 0, 1, 0);
        step(1, 5, 12'hFFF, 0, 0);
        step(1, 5, 12'hFFF, 1, 1);
        drain(0, 0);
        step(0, 0, 0, 1, 1);
        drain(0, 0);
        step(0, 0, 0, 0, 0);

        // Same-cycle write to index 0 and frame_done.
        step(1, 0, 12'hABC, 1, 0);
        drain(2, 0);
        step(0, 0, 0, 0, 0);

        // Reset after 100 beats.
        step(0, 0, 0, 1, 1);
        while (m_beats < 100) step(0, 0, 0, 0, 1);
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        drain(0, 0);

        // frame_done coincident with frame_sent: back-to-back drains.
        step(0, 0, 0, 1, 1);
        drain(0, 0);
        step(0, 0, 0, 0, 0);

        // Random frames, random ready, stray writes and frame_done during drain.
        for (int f = 0; f < 3; f++) begin
            fill(1);
            step($urandom_range(0, 1), 0, $urandom, 1, $urandom_range(0, 1));
            drain(2, 1);
            step(0, 0, 0, 0, 0);
        end
        step(0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
